// File: rtl/yv_bank_addr_sequencer_if.sv
// Signal bundle between the Y/V read-address sequencer and its surroundings:
// sweep control, Y SRAM fetch, V bank read ports and accumulate-stage status.
interface yv_bank_addr_sequencer_if #(
  parameter int unsigned N_LANES = 4,
  parameter int unsigned N_BANKS = 4,
  parameter int unsigned BANK_AW = 9,
  parameter int unsigned INFO_W  = 16,
  parameter int unsigned ROW_W   = 11
);
  localparam int unsigned BW = $clog2(N_BANKS);

  logic                       start;
  logic                       ping;
  logic                       stall;
  logic [N_LANES*INFO_W-1:0]  y_info;
  logic                       y_rd_en;
  logic [ROW_W-1:0]           y_addr;
  logic [N_BANKS-1:0]         bank_en_a;
  logic [N_BANKS-1:0]         bank_en_b;
  logic [N_BANKS*BANK_AW-1:0] bank_addr_a;
  logic [N_BANKS*BANK_AW-1:0] bank_addr_b;
  logic [N_LANES-1:0]         lane_issue;
  logic [N_LANES*BW-1:0]      lane_bank;
  logic [N_LANES-1:0]         lane_port;
  logic [N_LANES-1:0]         lane_eor;
  logic                       row_done;
  logic                       sweep_done;
  logic                       busy;

  modport master (
    output start, ping, stall, y_info,
    input  y_rd_en, y_addr, bank_en_a, bank_en_b, bank_addr_a, bank_addr_b,
    input  lane_issue, lane_bank, lane_port, lane_eor, row_done, sweep_done, busy
  );

  modport slave (
    input  start, ping, stall, y_info,
    output y_rd_en, y_addr, bank_en_a, bank_en_b, bank_addr_a, bank_addr_b,
    output lane_issue, lane_bank, lane_port, lane_eor, row_done, sweep_done, busy
  );
endinterface

// File: rtl/yv_bank_addr_sequencer.sv
// Y/V read-address sequencer: fetches one Y word per row, decodes lanes into V bank
// reads and issues them on two ports per bank, spreading conflicts over cycles.
module yv_bank_addr_sequencer #(
  parameter int unsigned N_LANES  = 4,
  parameter int unsigned N_BANKS  = 4,
  parameter int unsigned BANK_AW  = 9,
  parameter int unsigned INFO_W   = 16,
  parameter int unsigned ROW_W    = 11,
  parameter int unsigned ROW_BASE = 63,
  parameter int unsigned N_ROWS   = 64
) (
  input logic                     clock_i,
  input logic                     reset_i,
  yv_bank_addr_sequencer_if.slave bus_io
);
  localparam int unsigned BW = $clog2(N_BANKS);
  localparam int unsigned CW = $clog2(N_ROWS + 1);
  localparam logic [CW-1:0]    LastRow = CW'(N_ROWS - 1);
  localparam logic [ROW_W-1:0] RowBase = ROW_W'(ROW_BASE);

  typedef enum logic [2:0] {StIdle, StFetch, StWait, StIssue, StAdvance, StDone} state_e;

  state_e                    state_q;
  logic [ROW_W-1:0]          row_q;
  logic [CW-1:0]             cnt_q;
  logic                      ping_q;
  logic [N_LANES*INFO_W-1:0] info_q;
  logic [N_LANES-1:0]        pending_q, pending_d, eor_q, in_eor, issue;

  logic [BW-1:0]      dec_bank [N_LANES];
  logic [BANK_AW-2:0] dec_col  [N_LANES];
  logic [N_BANKS-1:0] en_a, en_b;
  logic [BANK_AW-1:0] addr_a [N_BANKS];
  logic [BANK_AW-1:0] addr_b [N_BANKS];
  logic [BW-1:0]      gbank [N_LANES];
  logic [N_LANES-1:0] gport;
  logic               unused_info;

  // Markers come from the live Y word (WAIT); bank/column from the captured copy (ISSUE).
  always_comb begin
    for (int l = 0; l < N_LANES; l++) begin
      in_eor[l]   = &bus_io.y_info[l*INFO_W+INFO_W-3 +: 3];
      dec_bank[l] = info_q[l*INFO_W +: BW];
      dec_col[l]  = info_q[l*INFO_W+BW +: BANK_AW-1];
    end
  end

  assign unused_info = ^info_q;

  // Ascending-lane scan: first pending lane of a bank takes port A, second takes port B.
  always_comb begin
    en_a  = '0;
    en_b  = '0;
    issue = '0;
    gport = '0;
    for (int b = 0; b < N_BANKS; b++) begin
      addr_a[b] = '0;
      addr_b[b] = '0;
    end
    for (int l = 0; l < N_LANES; l++) gbank[l] = '0;
    if (state_q == StIssue && !bus_io.stall) begin
      for (int l = 0; l < N_LANES; l++) begin
        if (pending_q[l]) begin
          if (!en_a[dec_bank[l]]) begin
            en_a[dec_bank[l]]   = 1'b1;
            addr_a[dec_bank[l]] = {ping_q, dec_col[l]};
            issue[l]            = 1'b1;
            gbank[l]            = dec_bank[l];
          end else if (!en_b[dec_bank[l]]) begin
            en_b[dec_bank[l]]   = 1'b1;
            addr_b[dec_bank[l]] = {ping_q, dec_col[l]};
            issue[l]            = 1'b1;
            gport[l]            = 1'b1;
            gbank[l]            = dec_bank[l];
          end
        end
      end
    end
  end

  assign pending_d = pending_q & ~issue;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q   <= StIdle;
      row_q     <= RowBase;
      cnt_q     <= '0;
      ping_q    <= 1'b0;
      info_q    <= '0;
      pending_q <= '0;
      eor_q     <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus_io.start) begin
            state_q <= StFetch;
            row_q   <= RowBase;
            cnt_q   <= '0;
            ping_q  <= bus_io.ping;
          end
        end
        StFetch: state_q <= StWait;
        StWait: begin
          info_q    <= bus_io.y_info;
          eor_q     <= in_eor;
          pending_q <= ~in_eor;
          state_q   <= (|(~in_eor)) ? StIssue : StAdvance;
        end
        StIssue: begin
          pending_q <= pending_d;
          if (pending_d == '0) state_q <= StAdvance;
        end
        StAdvance: begin
          row_q <= row_q + 1'b1;
          eor_q <= '0;
          if (cnt_q == LastRow) begin
            state_q <= StDone;
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            state_q <= StFetch;
          end
        end
        StDone:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
    assign bus_io.bank_addr_a[b*BANK_AW +: BANK_AW] = addr_a[b];
    assign bus_io.bank_addr_b[b*BANK_AW +: BANK_AW] = addr_b[b];
  end

  for (genvar l = 0; l < N_LANES; l++) begin : g_lane
    assign bus_io.lane_bank[l*BW +: BW] = gbank[l];
  end

  assign bus_io.bank_en_a  = en_a;
  assign bus_io.bank_en_b  = en_b;
  assign bus_io.lane_issue = issue;
  assign bus_io.lane_port  = gport;
  assign bus_io.lane_eor   = eor_q;
  assign bus_io.y_rd_en    = (state_q == StFetch);
  assign bus_io.y_addr     = (state_q == StFetch) ? row_q : '0;
  assign bus_io.row_done   = (state_q == StAdvance);
  assign bus_io.sweep_done = (state_q == StDone);
  assign bus_io.busy       = (state_q != StIdle);
endmodule
